// File: rtl/detector_ctrl_pkg.sv
// rtl/detector_ctrl_pkg.sv - shared types and sizing helpers for the spike-detector sequencer
package detector_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN
    } state_t;

    localparam int THR_W_DEF      = 12;
    localparam int SETTLE_CYC_DEF = 16;
    localparam int REFRAC_CYC_DEF = 8;
    localparam int CNT_W_DEF      = 16;

    // Bits needed for a down/up counter whose largest value is max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int BIT_IDX_W_DEF = cnt_w(THR_W_DEF - 1);
    localparam int SETTLE_W_DEF  = cnt_w(SETTLE_CYC_DEF - 1);
    localparam int REFRAC_W_DEF  = cnt_w(REFRAC_CYC_DEF);

endpackage

// File: rtl/detector_ctrl_cfg_shifter.sv
// rtl/detector_ctrl_cfg_shifter.sv - parallel-load, MSB-first serialiser for the detector threshold
module detector_ctrl_cfg_shifter
    import detector_ctrl_pkg::*;
#(
    parameter int THR_W = THR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [THR_W-1:0] word,
    output logic             enable,
    output logic             din,
    output logic             done
);

    localparam int IW = cnt_w(THR_W - 1);

    logic [THR_W-1:0] sreg;
    logic [IW-1:0]    idx;
    logic             busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg   <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            enable <= 1'b0;
            din    <= 1'b0;
        end else if (start) begin
            sreg   <= word;
            idx    <= IW'(THR_W - 1);
            busy   <= 1'b1;
            enable <= 1'b0;
            din    <= 1'b0;
        end else if (busy) begin
            enable <= 1'b1;
            din    <= sreg[idx];
            busy   <= (idx != '0);
            if (idx != '0) begin
                idx <= idx - IW'(1);
            end
        end else begin
            enable <= 1'b0;
            din    <= 1'b0;
        end
    end

    // High during the cycle the last bit is on the wire.
    assign done = enable & ~busy;

endmodule

// File: rtl/detector_ctrl.sv
// rtl/detector_ctrl.sv - threshold load, settle blanking and refractory spike gating for the detector chain
module detector_ctrl
    import detector_ctrl_pkg::*;
#(
    parameter int THR_W      = THR_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int REFRAC_CYC = REFRAC_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [THR_W-1:0] cfg_thr,
    output logic             cfg_ready,
    output logic             enable,
    output logic             din,
    input  logic             spike_in,
    output logic             spike_out,
    output logic             armed,
    output logic [CNT_W-1:0] spike_cnt
);

    localparam int SW = cnt_w(SETTLE_CYC - 1);
    localparam int RW = cnt_w(REFRAC_CYC);

    state_t           state, state_d;
    logic [SW-1:0]    settle_cnt, settle_cnt_d;
    logic [RW-1:0]    refrac_cnt, refrac_cnt_d;
    logic [CNT_W-1:0] spike_cnt_d;
    logic             cfg_ready_d, armed_d, spike_out_d;
    logic             accept, start, done;

    assign accept = cfg_valid & cfg_ready;

    detector_ctrl_cfg_shifter #(.THR_W(THR_W)) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .word   (cfg_thr),
        .enable (enable),
        .din    (din),
        .done   (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            refrac_cnt <= '0;
            spike_cnt  <= '0;
            cfg_ready  <= 1'b1;
            armed      <= 1'b0;
            spike_out  <= 1'b0;
        end else begin
            state      <= state_d;
            settle_cnt <= settle_cnt_d;
            refrac_cnt <= refrac_cnt_d;
            spike_cnt  <= spike_cnt_d;
            cfg_ready  <= cfg_ready_d;
            armed      <= armed_d;
            spike_out  <= spike_out_d;
        end
    end

    always_comb begin
        state_d      = state;
        settle_cnt_d = settle_cnt;
        refrac_cnt_d = refrac_cnt;
        spike_cnt_d  = spike_cnt;
        cfg_ready_d  = cfg_ready;
        armed_d      = armed;
        spike_out_d  = 1'b0;
        start        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    start       = 1'b1;
                    state_d     = LOAD;
                    cfg_ready_d = 1'b0;
                end
            end
            LOAD: begin
                if (done) begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                    spike_cnt_d  = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    state_d     = RUN;
                    armed_d     = 1'b1;
                    cfg_ready_d = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt + SW'(1);
                end
            end
            RUN: begin
                // A reconfiguration accept takes priority over a coincident spike.
                if (accept) begin
                    start        = 1'b1;
                    state_d      = LOAD;
                    cfg_ready_d  = 1'b0;
                    armed_d      = 1'b0;
                    refrac_cnt_d = '0;
                end else if (refrac_cnt != '0) begin
                    refrac_cnt_d = refrac_cnt - RW'(1);
                end else if (spike_in) begin
                    spike_out_d  = 1'b1;
                    refrac_cnt_d = RW'(REFRAC_CYC);
                    if (spike_cnt != {CNT_W{1'b1}}) begin
                        spike_cnt_d = spike_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
